apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB4 initiator that converts a simple valid/ready command stream into single APB transfers and returns each result on a valid/ready response stream. It is the requester side for APB completers such as the RTC register block. Firmware-model or DMA-style logic uses it to drive the peripheral bus. It runs one transfer at a time and has a programmable ACCESS-phase timeout so a stalled completer cannot hang the bus.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width (multiple of 8)
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase length in cycles; 0 disables the timeout
- pclk  input  1  clock; all logic is rising-edge
- prst_n  input  1  reset; synchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when valid&&ready
- cmd_addr  input  ADDR_W  transfer address
- cmd_write  input  1  1=write, 0=read
- cmd_wdata  input  DATA_W  write data
- cmd_strb  input  DATA_W/8  write byte strobes
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when valid&&ready
- rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts
- rsp_err  output  1  pslverr seen, or timeout
- rsp_timeout  output  1  transfer aborted by timeout
- m_apb_paddr  output  ADDR_W  APB address
- m_apb_psel  output  1  APB select
- m_apb_penable  output  1  APB enable
- m_apb_pwrite  output  1  APB direction
- m_apb_pwdata  output  DATA_W  APB write data
- m_apb_pstrb  output  DATA_W/8  APB strobes
- m_apb_pready  input  1  completer ready
- m_apb_prdata  input  DATA_W  completer read data
- m_apb_pslverr  input  1  completer error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset enters IDLE.
- **IDLE**
  - cmd_ready = 1, driven combinationally from the state. It is 0 in all other states.
  - When cmd_valid is 1, register addr, write, wdata and strb, then go to SETUP.
- **SETUP** (exactly one cycle)
  - psel = 1, penable = 0.
  - Go to ACCESS.
- **ACCESS**
  - psel = 1, penable = 1.
  - Stay in ACCESS while pready = 0.
  - When pready = 1: capture prdata for reads (rdata = 0 for writes), set rsp_err = pslverr and rsp_timeout = 0, then go to RESP.
- **Timeout**
  - If TIMEOUT_CYCLES > 0 and ACCESS has lasted TIMEOUT_CYCLES cycles with pready = 0, abort the transfer.
  - On abort: go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - If pready = 1 in the final allowed cycle, normal completion wins.
- **RESP**
  - rsp_valid = 1; rsp_* are held stable until rsp_ready = 1.
  - psel = 0, penable = 0.
  - When rsp_ready = 1, go to IDLE.
- **APB output rules**
  - paddr, pwrite, pwdata and pstrb are registered copies of the command. They are stable from SETUP through the last ACCESS cycle.
  - pstrb is forced to 0 for reads (APB4 rule).
  - psel and penable are never both driven high outside ACCESS. penable is never high without psel.
- **Timeout counter**
  - Width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1 bit.
  - Cleared on entry to ACCESS; increments every ACCESS cycle.
  - Saturates and never wraps.
- **Reset**
  - All outputs are 0 during reset, except cmd_ready, which is 0 while prst_n = 0 and becomes 1 the first cycle after release.
  - Reset asserted mid-transfer drops psel and penable at the next edge. The response is discarded.

## Timing
- Cycle 0: command handshake in IDLE.
- Cycle 1: SETUP.
- Cycle 2: first ACCESS cycle.
- Zero-wait completer (pready = 1 at cycle 2): rsp_valid = 1 at cycle 3.
- Each wait state adds one cycle.
- Response handshake in cycle N puts the FSM in IDLE at N+1. The next command can be accepted at N+1.
- Minimum period per transfer is 4 cycles.
- With a completer that never asserts pready: rsp_valid rises TIMEOUT_CYCLES+2 cycles after the command handshake.
- All outputs are registered except cmd_ready.

## Test plan
- **Zero-wait write:** write addr 0x10, wdata 0xDEADBEEF, strb 0xF.
  - Expect psel in cycle 1 and penable in cycle 2, with paddr = 0x10 and pwdata = 0xDEADBEEF.
  - Expect rsp_valid in cycle 3 with rsp_err = 0 and rdata = 0.
- **Read with 3 wait states:** completer returns prdata 0x12345678.
  - Expect ACCESS to last 4 cycles and pstrb = 0.
  - Expect rsp_rdata = 0x12345678 in cycle 6.
- **Slave error:** pslverr = 1 with pready on a write.
  - Expect rsp_err = 1 and rsp_timeout = 0.
- **Timeout:** TIMEOUT_CYCLES = 8 and pready held at 0.
  - Expect psel to drop after 8 ACCESS cycles.
  - Expect rsp_valid at cycle 10 with rsp_err = 1 and rsp_timeout = 1.
  - Repeat with pready = 1 in the 8th ACCESS cycle: expect normal completion.
- **Response backpressure:** hold rsp_ready = 0 for 5 cycles while cmd_valid = 1.
  - Expect rsp_* held stable, cmd_ready = 0 and psel = 0.
  - After the response handshake, expect the next command accepted one cycle later.
- **Reset mid-transfer:** assert prst_n = 0 during ACCESS.
  - Expect psel, penable and rsp_valid = 0 at the next edge.
  - Expect cmd_ready = 1 the first cycle after release.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB4 initiator: turns a valid/ready command stream into single APB transfers
// and returns each result (read data, slave error, timeout) on a response stream.
module apb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic                cmd_write,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   m_apb_paddr,
  output logic                m_apb_psel,
  output logic                m_apb_penable,
  output logic                m_apb_pwrite,
  output logic [DATA_W-1:0]   m_apb_pwdata,
  output logic [DATA_W/8-1:0] m_apb_pstrb,
  input  logic                m_apb_pready,
  input  logic [DATA_W-1:0]   m_apb_prdata,
  input  logic                m_apb_pslverr
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  // Counter value seen during the last ACCESS cycle that is still allowed.
  localparam logic [CNT_W-1:0] TO_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_reg;
  logic                rst_done_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                psel_reg;
  logic                penable_reg;
  logic                pwrite_reg;
  logic [ADDR_W-1:0]   paddr_reg;
  logic [DATA_W-1:0]   pwdata_reg;
  logic [STRB_W-1:0]   pstrb_reg;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                rsp_err_reg;
  logic                rsp_timeout_reg;
  logic [STRB_W-1:0]   strb_masked;
  logic                timeout_hit;

  // Reads must present all-zero strobes on the bus.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign strb_masked[gi] = cmd_strb[gi] & cmd_write;
    end
  endgenerate

  assign timeout_hit = TO_EN && (cnt_reg == TO_LAST);

  // Held low until the first edge that sees reset released.
  assign cmd_ready = rst_done_reg && (state_reg == IDLE);

  always_ff @(posedge pclk) begin
    if (!prst_n) begin
      state_reg       <= IDLE;
      rst_done_reg    <= 1'b0;
      cnt_reg         <= '0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      pwrite_reg      <= 1'b0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pstrb_reg       <= '0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      rst_done_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state_reg   <= SETUP;
            psel_reg    <= 1'b1;
            penable_reg <= 1'b0;
            paddr_reg   <= cmd_addr;
            pwrite_reg  <= cmd_write;
            pwdata_reg  <= cmd_wdata;
            pstrb_reg   <= strb_masked;
          end
        end
        SETUP: begin
          state_reg   <= ACCESS;
          penable_reg <= 1'b1;
          cnt_reg     <= '0;
        end
        ACCESS: begin
          if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
          // A ready completer in the final allowed cycle beats the timeout.
          if (m_apb_pready) begin
            state_reg       <= RESP;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= pwrite_reg ? '0 : m_apb_prdata;
            rsp_err_reg     <= m_apb_pslverr;
            rsp_timeout_reg <= 1'b0;
          end else if (timeout_hit) begin
            state_reg       <= RESP;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b1;
            rsp_timeout_reg <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg       <= IDLE;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_apb_psel    = psel_reg;
  assign m_apb_penable = penable_reg;
  assign m_apb_pwrite  = pwrite_reg;
  assign m_apb_paddr   = paddr_reg;
  assign m_apb_pwdata  = pwdata_reg;
  assign m_apb_pstrb   = pstrb_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign rsp_err       = rsp_err_reg;
  assign rsp_timeout   = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: walks zero-wait, wait-state, error, timeout,
// backpressure and mid-transfer reset scenarios against hand-computed values.
module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        prst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int n_cmp = 0;
  int n_err = 0;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .pclk(pclk), .prst_n(prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m_apb_paddr(paddr), .m_apb_psel(psel), .m_apb_penable(penable),
    .m_apb_pwrite(pwrite), .m_apb_pwdata(pwdata), .m_apb_pstrb(pstrb),
    .m_apb_pready(pready), .m_apb_prdata(prdata), .m_apb_pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("ok   %-22s observed=%08h", tag, obs);
    else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s);
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_valid = 1'b1;
  endtask

  initial begin
    prst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    prst_n = 1'b1;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Zero-wait write
    issue(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
    chk("wr_c0_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("wr_c1_psel", 32'(psel), 32'd1);
    chk("wr_c1_penable", 32'(penable), 32'd0);
    chk("wr_c1_paddr", paddr, 32'h10);
    chk("wr_c1_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_c1_pstrb", 32'(pstrb), 32'hF);
    chk("wr_c1_pwrite", 32'(pwrite), 32'd1);
    chk("wr_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    pready = 1'b1;
    tick();
    chk("wr_c2_psel", 32'(psel), 32'd1);
    chk("wr_c2_penable", 32'(penable), 32'd1);
    chk("wr_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    pready = 1'b0;
    chk("wr_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_c3_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_c3_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_c3_psel", 32'(psel), 32'd0);
    chk("wr_c3_penable", 32'(penable), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_c4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("wr_c4_cmd_ready", 32'(cmd_ready), 32'd1);

    // Read with 3 wait states
    issue(32'h20, 1'b0, 32'h0, 4'hF);
    tick();
    cmd_valid = 1'b0;
    chk("rd_c1_pstrb", 32'(pstrb), 32'd0);
    chk("rd_c1_pwrite", 32'(pwrite), 32'd0);
    chk("rd_c1_paddr", paddr, 32'h20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_wait_penable", 32'(penable), 32'd1);
    end
    tick();
    chk("rd_c5_penable", 32'(penable), 32'd1);
    chk("rd_c5_rsp_valid", 32'(rsp_valid), 32'd0);
    pready = 1'b1; prdata = 32'h12345678;
    tick();
    pready = 1'b0; prdata = '0;
    chk("rd_c6_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_c6_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_c6_rsp_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Slave error on a write
    issue(32'h30, 1'b1, 32'h55, 4'h3);
    tick();
    cmd_valid = 1'b0;
    chk("se_c1_pstrb", 32'(pstrb), 32'h3);
    tick();
    pready = 1'b1; pslverr = 1'b1;
    tick();
    pready = 1'b0; pslverr = 1'b0;
    chk("se_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("se_rsp_err", 32'(rsp_err), 32'd1);
    chk("se_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("se_rsp_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Timeout: completer never ready, 8 ACCESS cycles then abort
    issue(32'h40, 1'b0, 32'h0, 4'h0);
    prdata = 32'hAAAAAAAA;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("to_c9_psel", 32'(psel), 32'd1);
    chk("to_c9_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_c10_psel", 32'(psel), 32'd0);
    chk("to_c10_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_c10_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_c10_rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to_c10_rsp_rdata", rsp_rdata, 32'd0);
    prdata = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // pready in the 8th ACCESS cycle completes normally
    issue(32'h44, 1'b0, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    tick();
    chk("tl_c9_psel", 32'(psel), 32'd1);
    pready = 1'b1; prdata = 32'hCAFEF00D;
    tick();
    pready = 1'b0; prdata = '0;
    chk("tl_c10_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tl_c10_rsp_err", 32'(rsp_err), 32'd0);
    chk("tl_c10_rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("tl_c10_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Response backpressure with a second command waiting
    issue(32'h50, 1'b1, 32'h11223344, 4'hF);
    tick();
    issue(32'h60, 1'b0, 32'h0, 4'hF);
    pready = 1'b1;
    tick();
    tick();
    pready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_err", 32'(rsp_err), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_psel", 32'(psel), 32'd0);
      tick();
    end
    chk("bp_still_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_next_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("bp2_psel", 32'(psel), 32'd1);
    chk("bp2_penable", 32'(penable), 32'd0);
    chk("bp2_paddr", paddr, 32'h60);
    chk("bp2_pstrb", 32'(pstrb), 32'd0);
    pready = 1'b1; prdata = 32'h0BADCAFE;
    tick();
    tick();
    pready = 1'b0; prdata = '0;
    chk("bp2_rsp_rdata", rsp_rdata, 32'h0BADCAFE);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset asserted during ACCESS
    issue(32'h70, 1'b1, 32'h99, 4'h1);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("mr_access_penable", 32'(penable), 32'd1);
    prst_n = 1'b0;
    tick();
    chk("mr_psel", 32'(psel), 32'd0);
    chk("mr_penable", 32'(penable), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd0);
    prst_n = 1'b1;
    tick();
    chk("mr_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    pready = 1'b1;
    tick();
    pready = 1'b0;
    chk("mr_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rel_psel", 32'(psel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
